shabal_host_if: RTL and testbench
=================================

# shabal_host_if

Parametrised host-bus adapter for the hash cores. It packs a narrow host bus (BUS_W bits) into 32-bit message words, buffers them in a small FIFO, and paces them into the core under core_busy back-pressure, with block-boundary marking. It also latches the core digest and serialises it back to the host on fetch. It is the next-generation replacement for the fixed 16-bit interface and sits between the host pins and any 32-bit-word hash core.

## Interface
- BUS_W, 16, host bus width; legal values 8, 16, 32; R = 32/BUS_W beats per word
- DIGEST_WORDS, 8, 32-bit digest words (1..16)
- BLOCK_WORDS, 16, message words per core block (power of 2)
- FIFO_DEPTH, 4, message-word FIFO entries (power of 2, ≥2)
- MSW_FIRST, 1, 1: first beat fills the most-significant bits of a word or chunk; 0: least-significant
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous and active-high
- init  in  1  start a new message (one-cycle pulse)
- load  in  1  idata beat valid
- fetch  in  1  request the next digest chunk
- idata  in  BUS_W  host message beat
- ack  out  1  one-cycle pulse: beat or fetch accepted
- odata  out  BUS_W  digest chunk, registered
- overflow  out  1  sticky: a load was rejected
- core_init  out  1  one-cycle init pulse to core
- core_en  out  1  message-word strobe to core
- core_data  out  32  message word
- block_end  out  1  high with core_en on the last word of each block
- core_busy  in  1  core cannot accept a word this cycle
- core_done  in  1  pulse: core_digest valid
- core_digest  in  32*DIGEST_WORDS  digest; word k = bits [32k+31:32k]

## Operation
- States: IDLE (after reset), ABSORB, DIGEST.
- IDLE: load and fetch are ignored (no ack). init → ABSORB.
- ABSORB: loads are accepted. core_done → DIGEST.
- DIGEST: loads are ignored. init → ABSORB.
- init in any state (including ABSORB and DIGEST) performs the following, then pulses core_init in the next cycle:
  - clears the FIFO, beat counter, word counter, read pointer and overflow;
  - clears digest_valid;
  - takes precedence over load and fetch in the same cycle.
- Packing: a beat counter runs 0..R-1. Beat i fills slice i of the word, counted from the MSB end if MSW_FIRST=1, else from the LSB end. When beat R-1 arrives, the word is written to the FIFO.
- A load is rejected if the FIFO holds FIFO_DEPTH words, regardless of beat position. A rejected load gives no ack, sets overflow, and leaves the beat counter unchanged.
- Drain: when the FIFO is non-empty and core_busy=0, the block pops one word per cycle onto core_data with core_en=1. The block word counter increments mod BLOCK_WORDS. block_end=1 when the counter equals BLOCK_WORDS-1.
- A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- Digest:
  - core_done copies core_digest into a shadow register, sets digest_valid, and resets the read pointer.
  - Each fetch while digest_valid=1 loads odata with chunk p, then increments p. Chunk p is slice (p mod R) of word (p div R), with slice order set by MSW_FIRST.
  - p wraps from DIGEST_WORDS*R-1 to 0, so the digest can be re-read.
  - fetch while digest_valid=0: no ack, odata holds its value.
- load and fetch in the same cycle: both are serviced where legal, with a single ack pulse.
- A partial word left at core_done is discarded.

## Timing
- Reset values: ack, core_init, core_en, block_end and overflow are 0; odata and core_data are 0. State = IDLE; all counters are 0.
- ack is registered: it is high in cycle N+1 for a load or fetch accepted in cycle N.
- Word latency: if the last beat arrives in cycle N and the FIFO was empty with core_busy=0, then core_en is high in cycle N+1.
- core_en is never high in a cycle where core_busy was sampled high. core_data is stable while core_en=1.
- odata updates in the same cycle ack is high.
- core_init is high in cycle N+1 for init in cycle N. core_en stays 0 in that cycle.
- rst in mid-operation behaves exactly like the reset values above. Buffered words are lost and no core_init is issued.

## Test plan
- Packing, BUS_W=16, MSW_FIRST=1: init, then load 0x1234 and 0x5678 → one core_en with core_data=0x12345678 and ack after each beat. With MSW_FIRST=0 → 0x56781234.
- BUS_W=8: beats 0xDE, 0xAD, 0xBE, 0xEF → core_data=0xDEADBEEF. Then 16 words → block_end high only with the 16th core_en.
- Back-pressure: core_busy=1, 9 loads at BUS_W=16 → 8 acks, the 9th has no ack, overflow=1. Release core_busy → 4 consecutive core_en cycles in FIFO order.
- Digest readout: core_digest word0=0x01234567, word1=0x89ABCDEF, core_done → fetches return 0x0123, 0x4567, 0x89AB, 0xCDEF. The 17th fetch returns 0x0123 (wrap).
- Simultaneous events and illegal requests:
  - init with load in the same cycle → no ack, FIFO empty, core_init next cycle;
  - fetch before core_done → no ack.
- Reset mid-absorb: 3 beats, then rst → all outputs 0 and state IDLE; a subsequent load is ignored until init.

Source files
------------

// File: rtl/shabal_host_if_if.sv
// Host-side bus of the hash-core adapter: message beats in, digest chunks out.
interface shabal_host_if_if #(parameter int BUS_W = 16);
    logic             init;
    logic             load;
    logic             fetch;
    logic [BUS_W-1:0] idata;
    logic             ack;
    logic [BUS_W-1:0] odata;
    logic             overflow;

    modport master (output init, load, fetch, idata, input ack, odata, overflow);
    modport slave  (input init, load, fetch, idata, output ack, odata, overflow);
endinterface

// File: rtl/shabal_host_if.sv
// Packs BUS_W host beats into 32-bit message words, paces them into a hash core
// through a small FIFO, and serialises the latched digest back to the host.
module shabal_host_if #(
    parameter int BUS_W        = 16,
    parameter int DIGEST_WORDS = 8,
    parameter int BLOCK_WORDS  = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter bit MSW_FIRST    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    shabal_host_if_if.slave             host,
    output logic                        core_init,
    output logic                        core_en,
    output logic [31:0]                 core_data,
    output logic                        block_end,
    input  logic                        core_busy,
    input  logic                        core_done,
    input  logic [32*DIGEST_WORDS-1:0]  core_digest
);
    localparam int R   = 32 / BUS_W;
    localparam int BW  = (R > 1) ? $clog2(R) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WW  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int NCH = DIGEST_WORDS * R;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ABSORB = 2'd1;
    localparam logic [1:0] DIGEST = 2'd2;

    logic [1:0]                 state;
    logic [BW-1:0]              beat;
    logic [31:0]                acc;
    logic [31:0]                word;
    logic [31:0]                mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [AW:0]                cnt;
    logic [WW-1:0]              wcnt;
    logic [32*DIGEST_WORDS-1:0] shadow;
    logic                       digest_valid;
    logic [PW-1:0]              p;
    logic [BUS_W-1:0]           chunk;
    logic                       full;
    logic                       load_ok;
    logic                       fetch_ok;
    logic                       push;

    // Bus-width slot (counted from the LSB) that beat/chunk index idx occupies.
    function automatic int slot(input int idx);
        return MSW_FIRST ? (R - 1 - idx) : idx;
    endfunction

    assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
    assign load_ok   = host.load && !host.init && state == ABSORB && !full;
    assign fetch_ok  = host.fetch && !host.init && state != IDLE && digest_valid;
    assign push      = load_ok && beat == BW'(R - 1);
    assign core_en   = (cnt != '0) && !core_busy;
    assign core_data = core_en ? mem[rd_ptr] : '0;
    assign block_end = core_en && wcnt == WW'(BLOCK_WORDS - 1);

    always_comb begin
        word = acc;
        word[slot(int'(beat)) * BUS_W +: BUS_W] = host.idata;
    end

    always_comb begin
        chunk = shadow[((int'(p) / R) * R + slot(int'(p) % R)) * BUS_W +: BUS_W];
    end

    // Storage only; occupancy and pointers live in the reset block below.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            acc           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            wcnt          <= '0;
            shadow        <= '0;
            digest_valid  <= 1'b0;
            p             <= '0;
            core_init     <= 1'b0;
            host.ack      <= 1'b0;
            host.odata    <= '0;
            host.overflow <= 1'b0;
        end else begin
            core_init <= host.init;
            host.ack  <= load_ok || fetch_ok;
            if (host.init) begin
                state         <= ABSORB;
                beat          <= '0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                cnt           <= '0;
                wcnt          <= '0;
                p             <= '0;
                digest_valid  <= 1'b0;
                host.overflow <= 1'b0;
            end else begin
                if (core_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    wcnt   <= (wcnt == WW'(BLOCK_WORDS - 1)) ? '0 : wcnt + 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(core_en);
                if (load_ok) begin
                    acc  <= word;
                    beat <= push ? '0 : beat + 1'b1;
                end
                if (host.load && state == ABSORB && full) host.overflow <= 1'b1;
                if (fetch_ok) begin
                    host.odata <= chunk;
                    p          <= (p == PW'(NCH - 1)) ? '0 : p + 1'b1;
                end
                // Placed last so a digest arrival overrides the pointer bump and drops a partial word.
                if (core_done) begin
                    shadow       <= core_digest;
                    digest_valid <= 1'b1;
                    p            <= '0;
                    if (state == ABSORB) begin
                        state <= DIGEST;
                        beat  <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_shabal_host_if.sv
// Bench for shabal_host_if: cycle model on the 16-bit MSW-first instance plus
// literal checks on it and on 8-bit and LSB-first instances.
module tb_shabal_host_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shabal_host_if_if #(.BUS_W(16)) h16 ();
    shabal_host_if_if #(.BUS_W(8))  h8 ();
    shabal_host_if_if #(.BUS_W(16)) hl ();

    logic         c_init, c_en, c_be, busy, done;
    logic [31:0]  c_data;
    logic [255:0] dig;
    logic         b_init, b_en, b_be, l_init, l_en, l_be;
    logic [31:0]  b_data, l_data;
    logic         zero = 1'b0;
    logic [255:0] zdig = '0;

    shabal_host_if #(.BUS_W(16), .DIGEST_WORDS(8), .BLOCK_WORDS(16), .FIFO_DEPTH(4), .MSW_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .host(h16), .core_init(c_init), .core_en(c_en), .core_data(c_data),
        .block_end(c_be), .core_busy(busy), .core_done(done), .core_digest(dig));
    shabal_host_if #(.BUS_W(8), .DIGEST_WORDS(8), .BLOCK_WORDS(16), .FIFO_DEPTH(4), .MSW_FIRST(1'b1)) dut8 (
        .clk(clk), .rst(rst), .host(h8), .core_init(b_init), .core_en(b_en), .core_data(b_data),
        .block_end(b_be), .core_busy(zero), .core_done(zero), .core_digest(zdig));
    shabal_host_if #(.BUS_W(16), .DIGEST_WORDS(8), .BLOCK_WORDS(16), .FIFO_DEPTH(4), .MSW_FIRST(1'b0)) dutl (
        .clk(clk), .rst(rst), .host(hl), .core_init(l_init), .core_en(l_en), .core_data(l_data),
        .block_end(l_be), .core_busy(zero), .core_done(zero), .core_digest(zdig));

    int checks = 0;
    int passed = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural model of the 16-bit MSW-first instance.
    int          m_state = 0;   // 0 idle, 1 absorb, 2 digest
    logic [31:0] q[$];
    int          m_beat = 0, m_words = 0, m_p = 0;
    logic [31:0] m_acc = '0;
    logic        m_ack = 0, m_ovf = 0, m_cinit = 0, m_dv = 0;
    logic [15:0] m_odata = '0;
    logic [31:0] m_dig [8];
    bit          mon_on = 0;

    always @(posedge clk) begin
        bit full, pop, lacc, facc;
        full = (q.size() == 4);
        pop  = (q.size() != 0) && !busy;
        lacc = 0;
        facc = 0;
        if (rst) begin
            m_state = 0; q.delete(); m_beat = 0; m_words = 0; m_p = 0; m_acc = '0;
            m_ovf = 0; m_cinit = 0; m_dv = 0; m_odata = '0;
        end else begin
            m_cinit = h16.init;
            if (h16.init) begin
                m_state = 1; q.delete(); m_beat = 0; m_words = 0; m_p = 0; m_ovf = 0; m_dv = 0;
            end else begin
                if (pop) begin void'(q.pop_front()); m_words++; end
                if (h16.load && m_state == 1) begin
                    if (full) m_ovf = 1;
                    else begin
                        lacc  = 1;
                        m_acc = (m_acc << 16) | {16'h0, h16.idata};
                        if (m_beat == 1) begin q.push_back(m_acc); m_beat = 0; end
                        else m_beat = 1;
                    end
                end
                if (h16.fetch && m_state != 0 && m_dv) begin
                    facc    = 1;
                    m_odata = 16'(m_dig[m_p / 2] >> ((m_p % 2 == 0) ? 16 : 0));
                    m_p     = (m_p + 1) % 16;
                end
                if (done) begin
                    for (int k = 0; k < 8; k++) m_dig[k] = dig[32*k +: 32];
                    m_dv = 1; m_p = 0;
                    if (m_state == 1) begin m_state = 2; m_beat = 0; end
                end
            end
        end
        m_ack = lacc || facc;
    end

    always @(negedge clk) begin
        bit een;
        if (mon_on) begin
            een = (q.size() != 0) && !busy;
            check("ack", h16.ack, m_ack);
            check("odata", h16.odata, m_odata);
            check("overflow", h16.overflow, m_ovf);
            check("core_init", c_init, m_cinit);
            check("core_en", c_en, een);
            check("core_data", c_data, een ? q[0] : 32'h0);
            check("block_end", c_be, een && (m_words % 16 == 15));
        end
    end

    logic [31:0] seen[$], seen8[$], seenl[$];
    logic [15:0] rd16[$];
    bit          be8[$];
    int          ack_n = 0;
    always @(negedge clk) begin
        if (c_en) seen.push_back(c_data);
        if (h16.ack) begin ack_n++; rd16.push_back(h16.odata); end
        if (b_en) begin seen8.push_back(b_data); be8.push_back(b_be); end
        if (l_en) seenl.push_back(l_data);
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic beat16(input logic [15:0] d); h16.load = 1; h16.idata = d; tick(); h16.load = 0; endtask
    task automatic beat8(input logic [7:0] d);   h8.load = 1;  h8.idata = d;  tick(); h8.load = 0;  endtask
    task automatic beatl(input logic [15:0] d);  hl.load = 1;  hl.idata = d;  tick(); hl.load = 0;  endtask

    logic [31:0] bp_exp [4] = '{32'hA000A001, 32'hA002A003, 32'hA004A005, 32'hA006A007};
    logic [15:0] rd_exp [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    int          be_ones;

    initial begin
        {h16.init, h16.load, h16.fetch, h16.idata} = '0;
        {h8.init, h8.load, h8.fetch, h8.idata} = '0;
        {hl.init, hl.load, hl.fetch, hl.idata} = '0;
        busy = 0; done = 0;
        dig = '0;
        dig[31:0]  = 32'h01234567;
        dig[63:32] = 32'h89ABCDEF;
        for (int k = 2; k < 8; k++) dig[32*k +: 32] = 32'h11111111 * k;

        tick(); mon_on = 1;
        tick();
        check("rst_ack", h16.ack, 0);
        check("rst_odata", h16.odata, 0);
        check("rst_overflow", h16.overflow, 0);
        check("rst_core_en", c_en, 0);
        check("rst_core_data", c_data, 0);
        rst = 0; tick();

        // Idle: load and fetch ignored
        ack_n = 0;
        h16.load = 1; h16.idata = 16'hFFFF; h16.fetch = 1; tick();
        h16.load = 0; h16.fetch = 0; tick();
        check("idle_no_ack", ack_n, 0);

        // Packing
        h16.init = 1; tick(); h16.init = 0;
        check("core_init_pulse", c_init, 1);
        check("core_en_in_init", c_en, 0);
        ack_n = 0; seen.delete();
        beat16(16'h1234); beat16(16'h5678); tick(); tick();
        check("pack_count", seen.size(), 1);
        check("pack_word", seen.size() > 0 ? seen[0] : 32'h0, 32'h12345678);
        check("pack_acks", ack_n, 2);

        // Back-pressure
        busy = 1; ack_n = 0; seen.delete();
        for (int i = 0; i < 9; i++) beat16(16'hA000 + 16'(i));
        tick();
        check("bp_acks", ack_n, 8);
        check("bp_overflow", h16.overflow, 1);
        check("bp_no_drain", seen.size(), 0);
        busy = 0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_drained", seen.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_order", seen.size() > i ? seen[i] : 32'h0, bp_exp[i]);
        check("bp_empty", c_en, 0);

        // Digest readout
        h16.init = 1; tick(); h16.init = 0;
        check("init_clears_ovf", h16.overflow, 0);
        ack_n = 0;
        h16.fetch = 1; tick(); h16.fetch = 0; tick();
        check("fetch_before_done", ack_n, 0);
        done = 1; tick(); done = 0;
        rd16.delete(); ack_n = 0;
        h16.fetch = 1;
        for (int i = 0; i < 17; i++) tick();
        h16.fetch = 0; tick();
        check("fetch_count", rd16.size(), 17);
        for (int i = 0; i < 4; i++) check("fetch_chunk", rd16.size() > i ? rd16[i] : 16'h0, rd_exp[i]);
        check("fetch_chunk4", rd16.size() > 4 ? rd16[4] : 16'h0, 16'h2222);
        check("fetch_wrap", rd16.size() > 16 ? rd16[16] : 16'h0, 16'h0123);
        ack_n = 0;
        beat16(16'h9999); tick();
        check("digest_load_ignored", ack_n, 0);

        // init with load in the same cycle
        seen.delete();
        h16.init = 1; h16.load = 1; h16.idata = 16'hBEEF; tick();
        h16.init = 0; h16.load = 0;
        check("init_load_core_init", c_init, 1);
        check("init_load_no_ack", h16.ack, 0);
        tick(); tick();
        check("init_load_fifo_empty", seen.size(), 0);

        // Reset mid-absorb
        busy = 1;
        beat16(16'h1111); beat16(16'h2222); beat16(16'h3333);
        rst = 1; tick(); busy = 0; #1;
        check("mid_rst_ack", h16.ack, 0);
        check("mid_rst_ovf", h16.overflow, 0);
        check("mid_rst_core_en", c_en, 0);
        check("mid_rst_core_init", c_init, 0);
        rst = 0; ack_n = 0; seen.delete();
        beat16(16'h4444); beat16(16'h5555); tick(); tick();
        check("post_rst_ignored", ack_n, 0);
        check("post_rst_no_word", seen.size(), 0);
        h16.init = 1; tick(); h16.init = 0;
        beat16(16'h6666); beat16(16'h7777); tick(); tick();
        check("post_rst_word", seen.size() > 0 ? seen[0] : 32'h0, 32'h66667777);
        check("post_rst_count", seen.size(), 1);

        // 8-bit packing and block boundary
        h8.init = 1; tick(); h8.init = 0;
        seen8.delete(); be8.delete();
        beat8(8'hDE); beat8(8'hAD); beat8(8'hBE); beat8(8'hEF);
        for (int i = 1; i < 16; i++) begin
            beat8(8'(i)); beat8(8'hA5); beat8(8'h5A); beat8(8'(i));
        end
        tick(); tick();
        check("b8_count", seen8.size(), 16);
        check("b8_word0", seen8.size() > 0 ? seen8[0] : 32'h0, 32'hDEADBEEF);
        check("b8_word1", seen8.size() > 1 ? seen8[1] : 32'h0, 32'h01A55A01);
        be_ones = 0;
        foreach (be8[i]) if (be8[i]) be_ones++;
        check("b8_block_end_once", be_ones, 1);
        check("b8_block_end_16th", be8.size() > 15 ? be8[15] : 1'b0, 1);

        // LSB-first packing
        hl.init = 1; tick(); hl.init = 0;
        seenl.delete();
        beatl(16'h1234); beatl(16'h5678); tick(); tick();
        check("lsb_word", seenl.size() > 0 ? seenl[0] : 32'h0, 32'h56781234);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
